// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit. It handles one operand bit per clock
// and issues a single-cycle register-file writeback request when it finishes.
module muldiv_unit #(
   parameter int WIDTH      = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      operand_a,
   input  logic [WIDTH-1:0]      operand_b,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  busy,
   output logic                  wb_write_signal,
   output logic [REG_ADDR_W-1:0] wb_reg,
   output logic [WIDTH-1:0]      wb_data,
   output logic                  div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic [WIDTH-1:0]      opnd_q, opnd_d;
   logic [WIDTH-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]      lo_q, lo_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wb_write_q, wb_write_d;
   logic                  dbz_q, dbz_d;
   logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;
   logic [WIDTH-1:0]      wb_data_q, wb_data_d;

   logic [WIDTH-1:0]      mul_addend;
   logic [WIDTH:0]        mul_sum;
   logic [WIDTH:0]        div_shift;
   logic [WIDTH-1:0]      div_diff;
   logic                  div_ge;
   logic [WIDTH-1:0]      acc_step;
   logic [WIDTH-1:0]      lo_step;

   // Multiply: acc holds the high half and lo holds the multiplier, which shifts
   // out as product bits shift in. Divide: acc holds the partial remainder and
   // lo holds the dividend, which shifts out as quotient bits shift in.
   always_comb begin
      mul_addend = lo_q[0] ? opnd_q : '0;
      mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
      div_shift  = {acc_q, lo_q[WIDTH-1]};
      div_ge     = div_shift >= {1'b0, opnd_q};
      // When div_ge holds, the difference is smaller than the divisor, so it fits in WIDTH bits.
      div_diff   = div_shift[WIDTH-1:0] - opnd_q;
      if (op_q[1]) begin
         acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
         lo_step  = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         acc_step = mul_sum[WIDTH:1];
         lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dest_d     = dest_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      cnt_d      = cnt_q;
      wb_write_d = 1'b0;
      dbz_d      = 1'b0;
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               op_d    = op;
               dest_d  = dest_reg;
               cnt_d   = '0;
               acc_d   = '0;
               opnd_d  = op[1] ? operand_b : operand_a;
               lo_d    = op[1] ? operand_a : operand_b;
            end
         end
         ST_RUN: begin
            acc_d = acc_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               // MULHI and DIVR both read acc; MULLO and DIVQ both read lo.
               state_d    = ST_DONE;
               cnt_d      = '0;
               wb_reg_d   = dest_q;
               wb_data_d  = op_q[0] ? acc_step : lo_step;
               wb_write_d = (dest_q != '0);
               dbz_d      = op_q[1] && (opnd_q == '0);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         dest_q     <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         wb_write_q <= 1'b0;
         dbz_q      <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dest_q     <= dest_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         cnt_q      <= cnt_d;
         wb_write_q <= wb_write_d;
         dbz_q      <= dbz_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign busy            = (state_q != ST_IDLE);
   assign wb_write_signal = wb_write_q;
   assign wb_reg          = wb_reg_q;
   assign wb_data         = wb_data_q;
   assign div_by_zero     = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit. Every expected result below was worked out by hand.
module tb_muldiv_unit;

   localparam logic [1:0] MULLO = 2'b00;
   localparam logic [1:0] MULHI = 2'b01;
   localparam logic [1:0] DIVQ  = 2'b10;
   localparam logic [1:0] DIVR  = 2'b11;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [2:0] dest_reg;
   logic       busy;
   logic       wb_write_signal;
   logic [2:0] wb_reg;
   logic [7:0] wb_data;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(8), .REG_ADDR_W(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op              (op),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .dest_reg        (dest_reg),
      .busy            (busy),
      .wb_write_signal (wb_write_signal),
      .wb_reg          (wb_reg),
      .wb_data         (wb_data),
      .div_by_zero     (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one operation. It scrambles the inputs after the start edge and
   // records what appears while busy is high (no comparisons are made here).
   task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] d, output int busy_cyc, output int wb_cnt,
                        output int dbz_cnt, output logic wr9, output logic [7:0] data9,
                        output logic [2:0] reg9, output logic dbz9);
      busy_cyc = 0; wb_cnt = 0; dbz_cnt = 0;
      wr9 = 1'b0; data9 = 8'h00; reg9 = 3'd0; dbz9 = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
      @(posedge clk);
      #1;
      start = 1'b0; operand_a = ~a; operand_b = b + 8'd1; dest_reg = ~d;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cyc++;
         if (wb_write_signal) wb_cnt++;
         if (div_by_zero) dbz_cnt++;
         if (busy_cyc == 9) begin
            wr9 = wb_write_signal; data9 = wb_data; reg9 = wb_reg; dbz9 = div_by_zero;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = MULLO; operand_a = 8'h00; operand_b = 8'h00; dest_reg = 3'd0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (wb_write_signal !== 1'b0) begin errors++; $display("FAIL reset_wb_write got %b want 0", wb_write_signal); end
      checks++; if (wb_reg !== 3'd0) begin errors++; $display("FAIL reset_wb_reg got %0d want 0", wb_reg); end
      checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL reset_wb_data got %h want 00", wb_data); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
      rst = 1'b0;
      $display("reset released: busy=%b wb_write=%b", busy, wb_write_signal);
   endtask

   task automatic test_multiply();
      logic [1:0] t_op   [6] = '{MULLO, MULHI, MULHI, MULLO, MULHI, MULLO};
      logic [7:0] t_a    [6] = '{8'd13, 8'd13, 8'd200, 8'd200, 8'hFF, 8'hFF};
      logic [7:0] t_b    [6] = '{8'd11, 8'd11, 8'd200, 8'd200, 8'hFF, 8'hFF};
      logic [2:0] t_d    [6] = '{3'd3, 3'd3, 3'd5, 3'd5, 3'd1, 3'd2};
      logic [7:0] t_exp  [6] = '{8'h8F, 8'h00, 8'h9C, 8'h40, 8'hFE, 8'h01};
      int bc, wc, dc; logic wr, dz; logic [7:0] dt; logic [2:0] rg;
      for (int i = 0; i < 6; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], t_d[i], bc, wc, dc, wr, dt, rg, dz);
         $display("mul[%0d] op=%0d a=%h b=%h -> busy=%0d wb=%0d data=%h reg=%0d", i, t_op[i], t_a[i], t_b[i], bc, wc, dt, rg);
         checks++; if (bc != 9) begin errors++; $display("FAIL mul%0d_busy_cycles got %0d want 9", i, bc); end
         checks++; if (wc != 1 || wr !== 1'b1) begin errors++; $display("FAIL mul%0d_wb_pulse got count %0d last %b want 1 1", i, wc, wr); end
         checks++; if (dt !== t_exp[i]) begin errors++; $display("FAIL mul%0d_data got %h want %h", i, dt, t_exp[i]); end
         checks++; if (rg !== t_d[i]) begin errors++; $display("FAIL mul%0d_reg got %0d want %0d", i, rg, t_d[i]); end
         checks++; if (dc != 0) begin errors++; $display("FAIL mul%0d_dbz got %0d want 0", i, dc); end
      end
   endtask

   task automatic test_divide();
      logic [1:0] t_op  [8] = '{DIVQ, DIVR, DIVR, DIVQ, DIVQ, DIVR, DIVQ, DIVR};
      logic [7:0] t_a   [8] = '{8'd200, 8'd200, 8'd5, 8'd5, 8'h55, 8'h55, 8'hFF, 8'hFF};
      logic [7:0] t_b   [8] = '{8'd7, 8'd7, 8'd9, 8'd9, 8'h00, 8'h00, 8'h01, 8'h10};
      logic [2:0] t_d   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd7, 3'd6, 3'd5};
      logic [7:0] t_exp [8] = '{8'h1C, 8'h04, 8'h05, 8'h00, 8'hFF, 8'h55, 8'hFF, 8'h0F};
      logic       t_dbz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int bc, wc, dc; logic wr, dz; logic [7:0] dt; logic [2:0] rg;
      for (int i = 0; i < 8; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], t_d[i], bc, wc, dc, wr, dt, rg, dz);
         $display("div[%0d] op=%0d a=%h b=%h -> busy=%0d wb=%0d data=%h reg=%0d dbz=%b", i, t_op[i], t_a[i], t_b[i], bc, wc, dt, rg, dz);
         checks++; if (bc != 9) begin errors++; $display("FAIL div%0d_busy_cycles got %0d want 9", i, bc); end
         checks++; if (wc != 1 || wr !== 1'b1) begin errors++; $display("FAIL div%0d_wb_pulse got count %0d last %b want 1 1", i, wc, wr); end
         checks++; if (dt !== t_exp[i]) begin errors++; $display("FAIL div%0d_data got %h want %h", i, dt, t_exp[i]); end
         checks++; if (rg !== t_d[i]) begin errors++; $display("FAIL div%0d_reg got %0d want %0d", i, rg, t_d[i]); end
         checks++; if (dz !== t_dbz[i] || dc != int'(t_dbz[i])) begin
            errors++; $display("FAIL div%0d_dbz got wb-cycle %b count %0d want %b", i, dz, dc, t_dbz[i]);
         end
      end
   endtask

   task automatic test_dest_zero();
      int bc, wc, dc; logic wr, dz; logic [7:0] dt; logic [2:0] rg;
      do_op(DIVQ, 8'h55, 8'h00, 3'd0, bc, wc, dc, wr, dt, rg, dz);
      $display("dest0 divq 55/00 -> busy=%0d wb=%0d dbz=%0d", bc, wc, dc);
      checks++; if (bc != 9) begin errors++; $display("FAIL dest0_div_busy got %0d want 9", bc); end
      checks++; if (wc != 0) begin errors++; $display("FAIL dest0_div_wb got %0d want 0", wc); end
      checks++; if (dc != 1 || dz !== 1'b1) begin errors++; $display("FAIL dest0_div_dbz got count %0d last %b want 1 1", dc, dz); end
      do_op(MULLO, 8'd3, 8'd4, 3'd0, bc, wc, dc, wr, dt, rg, dz);
      $display("dest0 mullo 3*4 -> busy=%0d wb=%0d dbz=%0d", bc, wc, dc);
      checks++; if (bc != 9) begin errors++; $display("FAIL dest0_mul_busy got %0d want 9", bc); end
      checks++; if (wc != 0) begin errors++; $display("FAIL dest0_mul_wb got %0d want 0", wc); end
      checks++; if (dc != 0) begin errors++; $display("FAIL dest0_mul_dbz got %0d want 0", dc); end
   endtask

   task automatic test_back_to_back();
      int wb_seen = 0;
      int cyc = 0;
      logic got = 1'b0;
      @(negedge clk);
      start = 1'b1; op = MULLO; operand_a = 8'd13; operand_b = 8'd11; dest_reg = 3'd3;
      @(posedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 4) begin
            start = 1'b1; op = DIVQ; operand_a = 8'd99; operand_b = 8'd3; dest_reg = 3'd6;
         end
         if (busy) cyc++;
         if (wb_write_signal) wb_seen++;
         if (k == 9) begin
            checks++; if (wb_write_signal !== 1'b1 || wb_data !== 8'h8F || wb_reg !== 3'd3) begin
               errors++; $display("FAIL b2b_first_result got wr=%b data=%h reg=%0d want 1 8f 3", wb_write_signal, wb_data, wb_reg);
            end
         end
      end
      checks++; if (cyc != 9 || wb_seen != 1) begin errors++; $display("FAIL b2b_first_timing got busy %0d wb %0d want 9 1", cyc, wb_seen); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy %b want 0", busy); end
      start = 1'b1; op = DIVR; operand_a = 8'd200; operand_b = 8'd7; dest_reg = 3'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if (wb_write_signal) begin
            got = 1'b1;
            checks++; if (wb_data !== 8'h04 || wb_reg !== 3'd4) begin
               errors++; $display("FAIL b2b_second_result got data=%h reg=%0d want 04 4", wb_data, wb_reg);
            end
         end
      end
      $display("b2b second op: wb seen=%b after %0d busy cycles", got, cyc);
      checks++; if (!got || cyc != 9) begin errors++; $display("FAIL b2b_second_timing got wb %b busy %0d want 1 9", got, cyc); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_idle got busy %b want 0", busy); end
   endtask

   task automatic test_async_reset();
      int bad_wb = 0;
      int bad_busy = 0;
      @(negedge clk);
      start = 1'b1; op = MULLO; operand_a = 8'hFF; operand_b = 8'hFF; dest_reg = 3'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before got %b want 1", busy); end
      rst = 1'b1;
      #1;
      $display("async reset mid-op: busy=%b wb=%b reg=%0d data=%h dbz=%b", busy, wb_write_signal, wb_reg, wb_data, div_by_zero);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
      checks++; if (wb_write_signal !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++; $display("FAIL arst_strobes got wr=%b dbz=%b want 0 0", wb_write_signal, div_by_zero);
      end
      checks++; if (wb_data !== 8'h00 || wb_reg !== 3'd0) begin
         errors++; $display("FAIL arst_wb_fields got data=%h reg=%0d want 00 0", wb_data, wb_reg);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (wb_write_signal) bad_wb++;
         if (busy) bad_busy++;
      end
      checks++; if (bad_wb != 0) begin errors++; $display("FAIL arst_no_wb got %0d pulses want 0", bad_wb); end
      checks++; if (bad_busy != 0) begin errors++; $display("FAIL arst_stays_idle got %0d busy cycles want 0", bad_busy); end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_dest_zero();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
